// File: rtl/pe_pkg.sv
// Shared definitions for the union-find processing elements.
//   STAGE_*     : broadcast stage encodings (STAGE_WIDTH bits)
//   addr_width  : address width from per-coordinate width and coordinate count
package pe_pkg;
  localparam int STAGE_WIDTH = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING  = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd4;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd5;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd6;

  function automatic int addr_width(input int per_dim_bits, input int dims);
    return per_dim_bits * dims;
  endfunction
endpackage

// File: rtl/pe_root_select.sv
// Masked minimum search over neighbour root addresses.
//   values  in  NC*AW  channel i at [i*AW +: AW]
//   mask    in  NC     channel i participates
//   min_val out AW     smallest participating value (all-ones when none)
//   valid   out 1      at least one channel participates
//   sel     out NC     one-hot, lowest index holding min_val
// Purely combinational.
module pe_root_select #(
  parameter int NC = 6,
  parameter int AW = 6
) (
  input  logic [NC*AW-1:0] values,
  input  logic [NC-1:0]    mask,
  output logic [AW-1:0]    min_val,
  output logic             valid,
  output logic [NC-1:0]    sel
);
  // Strict less-than while scanning upward keeps the lowest index on ties,
  // so sel can never become multi-hot.
  always_comb begin
    min_val = '1;
    valid   = 1'b0;
    sel     = '0;
    for (int i = 0; i < NC; i++) begin
      if (mask[i] && (!valid || values[i*AW +: AW] < min_val)) begin
        min_val = values[i*AW +: AW];
        valid   = 1'b1;
        sel     = NC'(1) << i;
      end
    end
  end
endmodule

// File: rtl/processing_unit_v3.sv
// Union-find processing element for one ancilla of the decoder array.
// Tracks cluster root, one-hot parent pointer, subtree parity and boundary
// contact across GROW/MERGE rounds; busy reports local convergence.
// Ports:
//   clk, reset (async, active-high)
//   global_stage            broadcast stage, registered once before use
//   measurement             syndrome bit, loaded in MEASUREMENT_LOADING
//   neighbor_*/parent_odd/child_* per-channel neighbour information
//   neighbor_increase       grow pulse on GROW entry (combinational)
//   parent_vector, cluster_parity, cluster_touching_boundary, odd, root, busy
// Optional build macro PE_STATS_EN adds stat_root_changes / stat_merge_cycles.
module processing_unit_v3
  import pe_pkg::*;
#(
  parameter int PER_DIM_BIT_WIDTH = 2,
  parameter int DIM_COUNT         = 3,
  parameter int NEIGHBOR_COUNT    = 6,
  parameter int ADDRESS           = 0,
  parameter int SETTLE_CYCLES     = 2,
  parameter int STAT_WIDTH        = 8,
  localparam int AW = addr_width(PER_DIM_BIT_WIDTH, DIM_COUNT),
  localparam int NC = NEIGHBOR_COUNT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [STAGE_WIDTH-1:0] global_stage,
  input  logic                   measurement,
  input  logic [NC-1:0]          neighbor_fully_grown,
  input  logic [NC*AW-1:0]       neighbor_root,
  input  logic [NC-1:0]          neighbor_parent_vector,
  input  logic [NC-1:0]          neighbor_is_boundary,
  input  logic [NC-1:0]          parent_odd,
  input  logic [NC-1:0]          child_cluster_parity,
  input  logic [NC-1:0]          child_touching_boundary,
  output logic                   neighbor_increase,
  output logic [NC-1:0]          parent_vector,
  output logic                   cluster_parity,
  output logic                   cluster_touching_boundary,
  output logic                   odd,
  output logic [AW-1:0]          root,
`ifdef PE_STATS_EN
  output logic [STAT_WIDTH-1:0]  stat_root_changes,
  output logic [STAT_WIDTH-1:0]  stat_merge_cycles,
`endif
  output logic                   busy
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES);

  logic [STAGE_WIDTH-1:0] stage, last_stage;
  logic                   m;
  logic [SW-1:0]          settle_cnt;

  logic [AW-1:0] cand;
  logic          cand_vld;
  logic [NC-1:0] cand_sel;
  logic          root_upd, np, nb, is_root, odd_nxt, change;

  pe_root_select #(.NC(NC), .AW(AW)) u_root_select (
    .values  (neighbor_root),
    .mask    (neighbor_fully_grown),
    .min_val (cand),
    .valid   (cand_vld),
    .sel     (cand_sel)
  );

  assign root_upd = cand_vld && (cand < root);
  // Parity folds in children that point here plus our own syndrome bit.
  assign np = (^(neighbor_parent_vector & child_cluster_parity)) ^ m;
  // Boundary counts only through grown edges or children already touching it.
  assign nb = (|(neighbor_parent_vector & child_touching_boundary)) |
              (|(neighbor_is_boundary & neighbor_fully_grown));
  assign is_root = (parent_vector == '0);
  // Non-roots inherit odd from their parent; roots decide it from the subtree.
  assign odd_nxt = is_root ? (np & ~nb) : |(parent_vector & parent_odd);
  assign change  = root_upd || (np != cluster_parity) ||
                   (nb != cluster_touching_boundary) || (odd_nxt != odd);

  assign neighbor_increase = odd && (stage == STAGE_GROW) && (last_stage != STAGE_GROW);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage                     <= STAGE_IDLE;
      last_stage                <= STAGE_IDLE;
      m                         <= 1'b0;
      root                      <= AW'(ADDRESS);
      parent_vector             <= '0;
      odd                       <= 1'b0;
      cluster_parity            <= 1'b0;
      cluster_touching_boundary <= 1'b0;
      settle_cnt                <= '0;
      busy                      <= 1'b0;
    end else begin
      stage      <= global_stage;
      last_stage <= stage;
      case (stage)
        STAGE_MEASUREMENT_LOADING: begin
          m                         <= measurement;
          cluster_parity            <= measurement;
          odd                       <= measurement;
          root                      <= AW'(ADDRESS);
          parent_vector             <= '0;
          cluster_touching_boundary <= 1'b0;
          settle_cnt                <= '0;
          busy                      <= 1'b0;
        end
        STAGE_MERGE: begin
          if (root_upd) begin
            root          <= cand;
            parent_vector <= cand_sel;
          end
          cluster_parity            <= np;
          cluster_touching_boundary <= nb;
          odd                       <= odd_nxt;
          // Busy drops only after SETTLE_CYCLES quiet cycles so neighbours
          // still propagating through us are not missed.
          if (change) begin
            settle_cnt <= SETTLE_INIT;
            busy       <= 1'b1;
          end else if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SW'(1);
            busy       <= (settle_cnt > SW'(1));
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_root_changes <= '0;
      stat_merge_cycles <= '0;
    end else if (stage == STAGE_MEASUREMENT_LOADING) begin
      stat_root_changes <= '0;
      stat_merge_cycles <= '0;
    end else if (stage == STAGE_MERGE) begin
      if (root_upd && (stat_root_changes != '1))
        stat_root_changes <= stat_root_changes + STAT_WIDTH'(1);
      if (busy && (stat_merge_cycles != '1))
        stat_merge_cycles <= stat_merge_cycles + STAT_WIDTH'(1);
    end
  end
`endif
endmodule

// File: tb/tb_processing_unit_v3.sv
module tb_processing_unit_v3;
  import pe_pkg::*;

  localparam int AW     = 6;
  localparam int NC     = 6;
  localparam int ADDR   = 9;
  localparam int SETTLE = 2;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [STAGE_WIDTH-1:0] global_stage = STAGE_IDLE;
  logic                   measurement = 1'b0;
  logic [NC-1:0]          nfg = '0, npv = '0, nib = '0, po = '0, ccp = '0, ctb = '0;
  logic [NC*AW-1:0]       nroot = '1;
  logic                   neighbor_increase, cluster_parity, cluster_touching_boundary, odd, busy;
  logic [NC-1:0]          parent_vector;
  logic [AW-1:0]          root;
`ifdef PE_STATS_EN
  logic [7:0]             stat_root_changes, stat_merge_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;

  always #5 clk = ~clk;

  processing_unit_v3 #(
    .PER_DIM_BIT_WIDTH(2), .DIM_COUNT(3), .NEIGHBOR_COUNT(NC),
    .ADDRESS(ADDR), .SETTLE_CYCLES(SETTLE), .STAT_WIDTH(8)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .global_stage              (global_stage),
    .measurement               (measurement),
    .neighbor_fully_grown      (nfg),
    .neighbor_root             (nroot),
    .neighbor_parent_vector    (npv),
    .neighbor_is_boundary      (nib),
    .parent_odd                (po),
    .child_cluster_parity      (ccp),
    .child_touching_boundary   (ctb),
    .neighbor_increase         (neighbor_increase),
    .parent_vector             (parent_vector),
    .cluster_parity            (cluster_parity),
    .cluster_touching_boundary (cluster_touching_boundary),
    .odd                       (odd),
    .root                      (root),
`ifdef PE_STATS_EN
    .stat_root_changes         (stat_root_changes),
    .stat_merge_cycles         (stat_merge_cycles),
`endif
    .busy                      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [STAGE_WIDTH-1:0] md_stage, md_last;
  logic [AW-1:0]          md_root;
  logic [NC-1:0]          md_pv;
  bit md_m, md_par, md_tb, md_odd, md_busy;
  bit md_active;      // a change has been seen since the last load
  int md_quiet;       // quiet MERGE cycles since the last change
  int best, ones;
  bit upd, np_m, nb_m, odd_m, chg;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      md_stage = STAGE_IDLE; md_last = STAGE_IDLE;
      md_root = AW'(ADDR); md_pv = '0;
      md_m = 0; md_par = 0; md_tb = 0; md_odd = 0; md_busy = 0;
      md_active = 0; md_quiet = 0;
    end else begin
      if (md_stage == STAGE_MEASUREMENT_LOADING) begin
        md_m = measurement; md_par = measurement; md_odd = measurement;
        md_root = AW'(ADDR); md_pv = '0; md_tb = 0;
        md_busy = 0; md_active = 0; md_quiet = 0;
      end else if (md_stage == STAGE_MERGE) begin
        best = -1;
        for (int i = 0; i < NC; i++)
          if (nfg[i] && (best < 0 || nroot[i*AW +: AW] < nroot[best*AW +: AW])) best = i;
        upd  = (best >= 0) && (nroot[best*AW +: AW] < md_root);
        ones = $countones(npv & ccp) + int'(md_m);
        np_m = (ones % 2) == 1;
        nb_m = ($countones(npv & ctb) + $countones(nib & nfg)) > 0;
        if (md_pv == '0) odd_m = np_m && !nb_m;
        else             odd_m = (md_pv & po) != '0;
        chg = upd || (np_m != md_par) || (nb_m != md_tb) || (odd_m != md_odd);
        if (upd) begin
          md_root = nroot[best*AW +: AW];
          md_pv   = NC'(1) << best;
        end
        md_par = np_m; md_tb = nb_m; md_odd = odd_m;
        if (chg) begin
          md_active = 1; md_quiet = 0;
        end else if (md_active && md_quiet < SETTLE) begin
          md_quiet++;
        end
        md_busy = md_active && (md_quiet < SETTLE);
      end
      md_last  = md_stage;
      md_stage = global_stage;
    end
  end

  always @(negedge clk) begin
    if (armed && !reset) begin
      chk("root", 32'(root), 32'(md_root));
      chk("parent_vector", 32'(parent_vector), 32'(md_pv));
      chk("cluster_parity", 32'(cluster_parity), 32'(md_par));
      chk("touching_boundary", 32'(cluster_touching_boundary), 32'(md_tb));
      chk("odd", 32'(odd), 32'(md_odd));
      chk("busy", 32'(busy), 32'(md_busy));
      chk("neighbor_increase", 32'(neighbor_increase),
          32'(md_odd && md_stage == STAGE_GROW && md_last != STAGE_GROW));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_root(input int ch, input int val);
    nroot[ch*AW +: AW] = AW'(val);
  endtask

  int pulses;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    armed = 1'b1;
    chk("reset_root", 32'(root), ADDR);
    chk("reset_pv", 32'(parent_vector), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_ni", 32'(neighbor_increase), 0);

    // load odd syndrome, then grow pulse
    measurement = 1'b1; global_stage = STAGE_MEASUREMENT_LOADING;
    tick(2);
    chk("load_odd", 32'(odd), 1);
    chk("load_parity", 32'(cluster_parity), 1);
    global_stage = STAGE_GROW;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      pulses += int'(neighbor_increase);
    end
    chk("grow_pulses", pulses, 1);
    chk("grow_odd", 32'(odd), 1);

    // tie on ch1/ch3 at root 4; ungrown ch0 with smaller root is ignored
    global_stage = STAGE_MERGE;
    nfg = 6'b001010;
    set_root(0, 2); set_root(1, 4); set_root(3, 4);
    tick(2);
    chk("tie_root", 32'(root), 4);
    chk("tie_pv", 32'(parent_vector), 32'b000010);
    chk("tie_busy", 32'(busy), 1);

    // parent odd=0 drops our odd, then two quiet cycles close the window
    tick(1);
    chk("settle_busy0", 32'(busy), 1);
    chk("settle_odd", 32'(odd), 0);
    tick(1);
    chk("settle_busy1", 32'(busy), 1);
    tick(1);
    chk("settle_busy2", 32'(busy), 0);

    // reset mid-MERGE with root=3
    set_root(1, 3);
    tick(1);
    chk("pre_reset_root", 32'(root), 3);
    reset = 1'b1;
    #2;
    chk("async_reset_root", 32'(root), ADDR);
    tick(1);
    chk("reset_mid_root", 32'(root), ADDR);
    chk("reset_mid_pv", 32'(parent_vector), 0);
    chk("reset_mid_busy", 32'(busy), 0);
    reset = 1'b0;
    nfg = '0; nroot = '1;

    // child parity cancels own syndrome
    measurement = 1'b1; global_stage = STAGE_MEASUREMENT_LOADING;
    tick(2);
    global_stage = STAGE_MERGE;
    npv = 6'b000001; ccp = 6'b000001;
    tick(2);
    chk("child_parity", 32'(cluster_parity), 0);
    chk("child_odd", 32'(odd), 0);
    chk("child_busy", 32'(busy), 1);

    // boundary on ch2 counts only once the edge is grown
    nib = 6'b000100; ccp = '0;
    tick(1);
    chk("bnd_ungrown_tb", 32'(cluster_touching_boundary), 0);
    chk("bnd_ungrown_odd", 32'(odd), 1);
    nfg = 6'b000100;
    tick(1);
    chk("bnd_grown_tb", 32'(cluster_touching_boundary), 1);
    chk("bnd_grown_odd", 32'(odd), 0);
    chk("bnd_root", 32'(root), ADDR);

`ifdef PE_STATS_EN
    nfg = '0; nib = '0; npv = '0; nroot = '1;
    global_stage = STAGE_MEASUREMENT_LOADING;
    tick(2);
    chk("stat_clear0", 32'(stat_root_changes), 0);
    global_stage = STAGE_MERGE;
    nfg = 6'b000001;
    set_root(0, 8);
    tick(2);
    set_root(0, 5);
    tick(1);
    set_root(0, 2);
    tick(1);
    chk("stat_root_changes", 32'(stat_root_changes), 3);
    global_stage = STAGE_MEASUREMENT_LOADING;
    tick(2);
    chk("stat_clear1", 32'(stat_root_changes), 0);
    chk("stat_merge_clear", 32'(stat_merge_cycles), 0);
`endif

    tick(2);
    armed = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
